// File: rtl/pc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pc_sequencer_pkg
//   Shared definitions for the PC sequencer:
//   - bit positions of the 31-bit decoder control word
//   - a packed struct view of the control word
//   - Psel (PC-update select) encodings
//   - sequencer state encodings
//   - bit indices of the 5-bit status vector returned to the decoders
// ----------------------------------------------------------------------------
package pc_sequencer_pkg;

   // Control word field positions
   localparam int CW_WIDTH     = 31;
   localparam int CW_PSEL_MSB  = 30;
   localparam int CW_PSEL_LSB  = 29;
   localparam int CW_DA_MSB    = 28;
   localparam int CW_DA_LSB    = 24;
   localparam int CW_SA_MSB    = 23;
   localparam int CW_SA_LSB    = 19;
   localparam int CW_SB_MSB    = 18;
   localparam int CW_SB_LSB    = 14;
   localparam int CW_FSEL_MSB  = 13;
   localparam int CW_FSEL_LSB  = 9;
   localparam int CW_REGW      = 8;
   localparam int CW_RAMW      = 7;
   localparam int CW_EN_MEM    = 6;
   localparam int CW_EN_ALU    = 5;
   localparam int CW_EN_B      = 4;
   localparam int CW_EN_PC     = 3;
   localparam int CW_BSEL      = 2;
   localparam int CW_PCSEL     = 1;
   localparam int CW_SL        = 0;

   // PC update selection
   typedef enum logic [1:0] {
      PSEL_HOLD   = 2'b00,  // pc holds
      PSEL_INC    = 2'b01,  // pc + 4
      PSEL_LOAD   = 2'b10,  // pc = operand
      PSEL_BRANCH = 2'b11   // pc + 4 + (operand << 2)
   } psel_e;

   // Sequencer state; any non-fetch state is an execute step
   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_EX1   = 2'b01,
      ST_EX2   = 2'b10,
      ST_EX3   = 2'b11
   } state_e;

   // Packed view of the control word, MSB first, matching the positions above
   typedef struct packed {
      psel_e      psel;
      logic [4:0] da;
      logic [4:0] sa;
      logic [4:0] sb;
      logic [4:0] fsel;
      logic       reg_w;
      logic       ram_w;
      logic       en_mem;
      logic       en_alu;
      logic       en_b;
      logic       en_pc;
      logic       b_sel;
      logic       pc_sel;
      logic       sl;
   } ctrl_word_t;

   // Status vector bit indices: {V,C,Z,N latched, zi live}
   localparam int ST_BIT_V  = 4;
   localparam int ST_BIT_C  = 3;
   localparam int ST_BIT_Z  = 2;
   localparam int ST_BIT_N  = 1;
   localparam int ST_BIT_ZI = 0;

   // True for any execute step
   function automatic logic is_execute(input state_e s);
      return s != ST_FETCH;
   endfunction

endpackage

// File: rtl/pc_sequencer_pc_next.sv
// ----------------------------------------------------------------------------
// pc_next
//   Combinational next-PC selection for one execute cycle.
//   All arithmetic is 64-bit and wraps modulo 2^64.
// Ports:
//   pc       in  64  current PC
//   operand  in  64  selected operand (K or bus value)
//   psel     in   2  PC update select
//   next_pc  out 64  PC value to load at the end of the execute cycle
// ----------------------------------------------------------------------------
module pc_next
   import pc_sequencer_pkg::*;
(
   input  logic [63:0] pc,
   input  logic [63:0] operand,
   input  psel_e       psel,
   output logic [63:0] next_pc
);

   logic [63:0] pc_plus4;

   assign pc_plus4 = pc + 64'd4;

   // NOTE: assigning a default before the case guarantees every path writes
   // next_pc, so no latch can be inferred even if an encoding is added later.
   always_comb begin
      next_pc = pc;
      unique case (psel)
         PSEL_HOLD:   next_pc = pc;
         PSEL_INC:    next_pc = pc_plus4;
         PSEL_LOAD:   next_pc = operand;
         PSEL_BRANCH: next_pc = pc_plus4 + (operand << 2);
         default:     next_pc = pc;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//   Sequencing back end of a multi-cycle LEGv8-style core. Owns the PC,
//   instruction register, 2-bit state register and latched ALU flags.
//   FETCH issues imem_req until imem_ack, then captures the instruction.
//   Each EXECUTE cycle applies the decoder's PC-update and flag-latch fields
//   and moves to the decoder-requested next state.
// Ports:
//   clock        in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high
//   controlword  in  31   decoder control word
//   nextState    in   2   decoder-requested next state
//   K            in  64   decoder constant
//   bus_in       in  64   datapath bus (register target for PC load)
//   status_alu   in   4   live ALU flags {V,C,Z,N}
//   zi           in   1   live zero-detect
//   imem_req     out  1   fetch request
//   imem_addr    out 64   fetch address
//   imem_ack     in   1   fetch complete, imem_rdata valid
//   imem_rdata   in  32   fetched instruction
//   instruction  out 32   instruction register
//   state        out  2   current state
//   status       out  5   {V,C,Z,N latched, zi live}
//   pc           out 64   current PC
//   pc_bus       out 64   PC value for the datapath bus
//   pc_bus_en    out  1   drive pc_bus onto the bus
// ----------------------------------------------------------------------------
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [63:0] PC_RESET = 64'h0
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [30:0] controlword,
   input  logic [1:0]  nextState,
   input  logic [63:0] K,
   input  logic [63:0] bus_in,
   input  logic [3:0]  status_alu,
   input  logic        zi,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [1:0]  state,
   output logic [4:0]  status,
   output logic [63:0] pc,
   output logic [63:0] pc_bus,
   output logic        pc_bus_en
);

   ctrl_word_t  cw;
   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [3:0]  flags_q, flags_d;
   logic [63:0] operand;
   logic [63:0] pc_candidate;
   logic        in_execute;

   assign cw         = ctrl_word_t'(controlword);
   assign in_execute = is_execute(state_q);
   assign operand    = cw.pc_sel ? K : bus_in;

   pc_next u_pc_next (
      .pc      (pc_q),
      .operand (operand),
      .psel    (cw.psel),
      .next_pc (pc_candidate)
   );

   // Next-state / next-value logic; everything holds unless a state says
   // otherwise. Control word and nextState only matter while executing.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      flags_d = flags_q;
      if (!in_execute) begin
         if (imem_ack) begin
            ir_d    = imem_rdata;
            state_d = ST_EX1;
         end
      end else begin
         state_d = state_e'(nextState);
         pc_d    = pc_candidate;
         if (cw.sl) begin
            flags_d = status_alu;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_FETCH;
         pc_q    <= PC_RESET;
         ir_q    <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         flags_q <= flags_d;
      end
   end

   // Request and bus enable are gated by reset so nothing is issued while
   // the sequencer is being cleared.
   assign imem_req    = !in_execute && !reset;
   assign imem_addr   = pc_q;
   assign pc_bus_en   = cw.en_pc && in_execute && !reset;
   assign pc_bus      = pc_q;
   assign pc          = pc_q;
   assign instruction = ir_q;
   assign state       = state_q;
   assign status      = {flags_q, zi};

   // Fields consumed by other datapath blocks, not by the sequencer
   logic unused_cw_fields;
   assign unused_cw_fields = ^{cw.da, cw.sa, cw.sb, cw.fsel, cw.reg_w, cw.ram_w,
                               cw.en_mem, cw.en_alu, cw.en_b, cw.b_sel};

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed self-checking bench for pc_sequencer. Inputs change 1 ns after
//   a rising edge; outputs are sampled there too, away from the edge.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [30:0] controlword;
   logic [1:0]  nextState;
   logic [63:0] K;
   logic [63:0] bus_in;
   logic [3:0]  status_alu;
   logic        zi;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic [1:0]  state;
   logic [4:0]  status;
   logic [63:0] pc;
   logic [63:0] pc_bus;
   logic        pc_bus_en;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(.PC_RESET(64'h0)) dut (
      .clock       (clock),
      .reset       (reset),
      .controlword (controlword),
      .nextState   (nextState),
      .K           (K),
      .bus_in      (bus_in),
      .status_alu  (status_alu),
      .zi          (zi),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instruction (instruction),
      .state       (state),
      .status      (status),
      .pc          (pc),
      .pc_bus      (pc_bus),
      .pc_bus_en   (pc_bus_en)
   );

   always #5 clock = ~clock;

   // Control word built from the field layout: {Psel, 25 don't-care bits,
   // EN_PC, Bsel, PCsel, SL}
   function automatic logic [30:0] mk_cw(input logic [1:0] psel, input logic pcsel,
                                         input logic sl, input logic en_pc);
      return {psel, 25'b0, en_pc, 1'b0, pcsel, sl};
   endfunction

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Zero-wait fetch of one instruction; leaves the sequencer in EX1
   task automatic do_fetch(input logic [31:0] word);
      imem_rdata = word;
      imem_ack   = 1'b1;
      step();
      imem_ack   = 1'b0;
      check("fetch_state", state, 2'b01);
      check("fetch_ir", instruction, word);
   endtask

   initial begin
      reset       = 1'b1;
      controlword = mk_cw(2'b00, 1'b0, 1'b0, 1'b1);
      nextState   = 2'b00;
      K           = '0;
      bus_in      = '0;
      status_alu  = '0;
      zi          = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = '0;

      // Reset held: request and bus enable forced low
      step();
      step();
      check("rst_req", imem_req, 1'b0);
      check("rst_bus_en", pc_bus_en, 1'b0);
      check("rst_pc", pc, 64'h0);

      // Reset release, EN_PC=1 while fetching still gives no bus enable
      reset = 1'b0;
      #1;
      check("rel_req", imem_req, 1'b1);
      check("rel_addr", imem_addr, 64'h0);
      check("rel_state", state, 2'b00);
      check("rel_status", status, 5'b0000_0);
      check("rel_bus_en", pc_bus_en, 1'b0);
      check("rel_ir", instruction, 32'h0);

      // Fetch with three wait cycles
      imem_rdata = 32'hB400_0041;
      for (int i = 0; i < 3; i++) begin
         step();
         check("wait_ir", instruction, 32'h0);
         check("wait_pc", pc, 64'h0);
         check("wait_state", state, 2'b00);
         check("wait_req", imem_req, 1'b1);
      end
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      check("ack_ir", instruction, 32'hB400_0041);
      check("ack_state", state, 2'b01);
      check("ack_pc", pc, 64'h0);
      check("ex_req", imem_req, 1'b0);

      // EX: load pc from K=0x100; ack during execute is ignored
      controlword = mk_cw(2'b10, 1'b1, 1'b0, 1'b1);
      K           = 64'h100;
      nextState   = 2'b00;
      imem_ack    = 1'b1;
      imem_rdata  = 32'h1234_5678;
      #1;
      check("ex_bus_en", pc_bus_en, 1'b1);
      step();
      imem_ack = 1'b0;
      check("load_k_pc", pc, 64'h100);
      check("load_k_state", state, 2'b00);
      check("ex_ack_ignored", instruction, 32'hB400_0041);
      check("pc_bus", pc_bus, 64'h100);

      // Branch: 0x100 + 4 + (2<<2) = 0x10C
      do_fetch(32'h0000_0001);
      controlword = mk_cw(2'b11, 1'b1, 1'b0, 1'b0);
      K           = 64'h2;
      nextState   = 2'b00;
      step();
      check("branch_pc", pc, 64'h10C);
      check("branch_state", state, 2'b00);

      // Two-step: load 0x100 staying in EX1, then increment to 0x104
      do_fetch(32'h0000_0002);
      controlword = mk_cw(2'b10, 1'b1, 1'b0, 1'b0);
      K           = 64'h100;
      nextState   = 2'b01;
      step();
      check("reload_pc", pc, 64'h100);
      check("reload_state", state, 2'b01);
      controlword = mk_cw(2'b01, 1'b1, 1'b0, 1'b0);
      nextState   = 2'b00;
      step();
      check("inc_pc", pc, 64'h104);
      check("inc_state", state, 2'b00);

      // Register load from bus into EX2, then hold
      do_fetch(32'h0000_0003);
      controlword = mk_cw(2'b10, 1'b0, 1'b0, 1'b0);
      K           = 64'h5555;
      bus_in      = 64'h2000;
      nextState   = 2'b10;
      step();
      check("bus_load_pc", pc, 64'h2000);
      check("bus_load_state", state, 2'b10);
      controlword = mk_cw(2'b00, 1'b0, 1'b0, 1'b0);
      nextState   = 2'b00;
      step();
      check("hold_pc", pc, 64'h2000);
      check("hold_state", state, 2'b00);

      // Wrap: load 0xFFFF_FFFF_FFFF_FFFC into EX3, then +4 wraps to 0
      do_fetch(32'h0000_0004);
      controlword = mk_cw(2'b10, 1'b1, 1'b0, 1'b0);
      K           = 64'hFFFF_FFFF_FFFF_FFFC;
      nextState   = 2'b11;
      step();
      check("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
      check("ex3_state", state, 2'b11);
      controlword = mk_cw(2'b01, 1'b0, 1'b0, 1'b0);
      nextState   = 2'b00;
      step();
      check("wrap_pc", pc, 64'h0);
      check("wrap_state", state, 2'b00);

      // Flag latch, then hold; zi passes straight through
      do_fetch(32'h0000_0005);
      controlword = mk_cw(2'b00, 1'b0, 1'b1, 1'b0);
      status_alu  = 4'b1010;
      zi          = 1'b0;
      nextState   = 2'b01;
      step();
      check("sl_status", status, 5'b1010_0);
      controlword = mk_cw(2'b01, 1'b0, 1'b0, 1'b0);
      status_alu  = 4'b0101;
      zi          = 1'b1;
      nextState   = 2'b00;
      #1;
      check("zi_live_hi", status, 5'b1010_1);
      step();
      check("flags_hold", status, 5'b1010_1);
      check("flags_pc", pc, 64'h4);
      zi = 1'b0;
      #1;
      check("zi_live_lo", status, 5'b1010_0);

      // Reset with a same-cycle ack: ack discarded, everything cleared
      imem_rdata = 32'hDEAD_BEEF;
      imem_ack   = 1'b1;
      reset      = 1'b1;
      step();
      check("rst_ack_ir", instruction, 32'h0);
      check("rst_ack_pc", pc, 64'h0);
      check("rst_ack_state", state, 2'b00);
      check("rst_ack_flags", status, 5'b0000_0);
      check("rst_ack_req", imem_req, 1'b0);
      imem_ack = 1'b0;
      reset    = 1'b0;

      // Reset mid-execute aborts the PC update
      do_fetch(32'h0000_0006);
      controlword = mk_cw(2'b01, 1'b0, 1'b1, 1'b1);
      status_alu  = 4'b1111;
      nextState   = 2'b10;
      reset       = 1'b1;
      #1;
      check("rst_ex_bus_en", pc_bus_en, 1'b0);
      step();
      check("rst_ex_pc", pc, 64'h0);
      check("rst_ex_state", state, 2'b00);
      check("rst_ex_flags", status, 5'b0000_0);
      reset = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Sequencing back end of the multi-cycle LEGv8-style core. It consumes the 31-bit control word, nextState and K driven by the per-class instruction decoders, and owns the architectural PC, the instruction register, the 2-bit state register and the latched status flags. It issues instruction fetches over a req/ack handshake, then applies each decoded control word's PC-update and flag-latch fields once per execute cycle. Its state and status outputs feed back into the decoders.

Parameters:
PC_RESET, 64'h0, PC value loaded on reset.

Ports:
clock  input  1  single system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clock
controlword  input  31  decoder output {Psel[30:29], DA[28:24], SA[23:19], SB[18:14], Fsel[13:9], regW[8], ramW[7], EN_MEM[6], EN_ALU[5], EN_B[4], EN_PC[3], Bsel[2], PCsel[1], SL[0]}
nextState  input  2  decoder-requested next state
K  input  64  decoder constant (branch offset / immediate)
bus_in  input  64  datapath bus value (register target for PC load)
status_alu  input  4  live ALU flags {V,C,Z,N}
zi  input  1  live zero-detect of current operand
imem_req  output  1  fetch request
imem_addr  output  64  fetch address
imem_ack  input  1  fetch complete; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
instruction  output  32  instruction register to decoders
state  output  2  current state to decoders
status  output  5  {V,C,Z,N latched, zi live} to decoders
pc  output  64  current PC
pc_bus  output  64  PC value for datapath bus
pc_bus_en  output  1  drive pc_bus onto bus

Behaviour:
- Reset (reset=1 at edge): pc<=PC_RESET, instruction<=0, state<=2'b00, latched flags<=4'b0. Reset has priority over imem_ack and all control-word fields. While reset=1, imem_req and pc_bus_en are forced 0.
- States: 00=FETCH; 01, 10, 11=EXECUTE steps.
- FETCH:
  - imem_req=1 and imem_addr=pc, combinational from the state register.
  - Waits any number of cycles with pc and instruction held.
  - On imem_ack=1: instruction<=imem_rdata, state<=01, pc unchanged.
  - controlword, nextState and K are ignored in FETCH.
- EXECUTE (state!=00):
  - imem_req=0; imem_ack is ignored.
  - Every cycle, state<=nextState. nextState=00 returns to FETCH.
  - Operand in = PCsel ? K : bus_in.
  - Psel 00: pc holds.
  - Psel 01: pc<=pc+4.
  - Psel 10: pc<=in.
  - Psel 11: pc<=pc+4+(in<<2).
  - Arithmetic is 64-bit modulo 2^64: overflow wraps and no flag is raised.
  - SL=1: flags<=status_alu. SL=0: flags hold.
- pc_bus=pc always. pc_bus_en=EN_PC && state!=00 && !reset.
- status={flags_q, zi}; zi is passed through combinationally with no latch.
- Latency:
  - Fetch completes at the edge where ack is seen; the first execute cycle follows.
  - The minimum instruction is 2 cycles: 1 fetch (zero-wait ack) plus 1 execute.
- Multi-step instructions chain EXECUTE states via nextState. PC updates in every execute cycle per that cycle's Psel, so decoders must drive Psel=00 on non-final steps.
- Reset mid-fetch or mid-execute aborts immediately. A same-cycle ack is discarded.

Decomposition:
- Shared package:
  - controlword field bit positions.
  - Psel encodings: PSEL_HOLD, PSEL_INC, PSEL_LOAD, PSEL_BRANCH.
  - State encodings: ST_FETCH, ST_EX1, ST_EX2, ST_EX3.
  - Status bit indices: V=4, C=3, Z=2, N=1, ZI=0.
- One sub-module, pc_next: combinational next-PC mux/adder (pc, in, Psel -> pc_next).

Test Plan:
- Reset release with PC_RESET=0 -> imem_req=1, imem_addr=0, state=00, status=5'b0000_x (zi live), pc_bus_en=0.
- FETCH with ack delayed 3 cycles, imem_rdata=32'hB400_0041 -> instruction and pc unchanged until the ack edge; then instruction=32'hB400_0041, state=01, pc unchanged.
- EXECUTE with pc=64'h100, Psel=11, PCsel=1, K=2, nextState=00 -> pc=64'h10C, state=00. Same setup with Psel=01 -> pc=64'h104.
- Psel=10, PCsel=0, bus_in=64'h2000, nextState=10 -> pc=64'h2000, state=10. Next cycle Psel=00, nextState=00 -> pc holds 64'h2000, state=00. pc=64'hFFFF_FFFF_FFFF_FFFC with Psel=01 -> pc=0.
- SL=1, status_alu=4'b1010 -> status[4:1]=1010. Next cycle SL=0, status_alu=4'b0101 -> status[4:1] stays 1010. Driving zi tracks status[0] in the same cycle.
- reset=1 in the same cycle as imem_ack=1 with rdata=32'hDEAD_BEEF -> instruction=0, pc=PC_RESET, state=00. EN_PC=1 during FETCH -> pc_bus_en=0.
